spi_scene_loader: RTL and testbench

//  Parses the SPI_Slave byte stream (recv_dv/recv_byte) into framed packets and writes validated payload

---
 rtl/scene_cfg_pkg.sv | 29 ++
 rtl/spi_payload_buf.sv | 43 ++++
 rtl/spi_scene_loader.sv | 214 +++++++++++++++++++++
 tb/tb_spi_scene_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scene_cfg_pkg.sv
// Shared definitions for the SPI scene loader and the raytracer scene-config register file.
// Frame bytes, loader FSM states and the config address map used by Raytracing_Controller.
package scene_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_WRITE  = 8'h10;
  localparam logic [7:0] CMD_COMMIT = 8'h20;

  // Scene-config word address map (base of each region)
  localparam logic [7:0] CFG_ADDR_CAMERA  = 8'h00;
  localparam logic [7:0] CFG_ADDR_LIGHT   = 8'h10;
  localparam logic [7:0] CFG_ADDR_SPHERES = 8'h20;
  localparam logic [7:0] CFG_ADDR_PLANE   = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } loader_state_t;

  // Number of 16-bit words carried by a WRITE payload of len bytes (first byte is ADDR).
  function automatic logic [7:0] word_count(input logic [7:0] len);
    return (len - 8'd1) >> 1;
  endfunction

endpackage

// File: rtl/spi_payload_buf.sv
// Byte buffer for one packet payload: sequential write pointer, ADDR byte and word read port.
// Word i is {buf[2i+1], buf[2i+2]}; buf[0] holds the base address.
module spi_payload_buf #(
  parameter int DEPTH = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [7:0]  wdata,
  input  logic [3:0]  word_idx,
  output logic [5:0]  wptr,
  output logic [7:0]  addr_byte,
  output logic [15:0] word
);

  logic [7:0] mem_q [DEPTH];
  logic [5:0] wptr_q;
  logic [5:0] hi_idx;
  logic [5:0] lo_idx;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_q <= '0;
    end else if (we) begin
      wptr_q <= wptr_q + 6'd1;
    end
  end

  // Storage is intentionally not reset; contents are only read after a full payload.
  always_ff @(posedge clk) begin
    if (we && (wptr_q < 6'(DEPTH))) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign hi_idx    = {1'b0, word_idx, 1'b0} + 6'd1;
  assign lo_idx    = {1'b0, word_idx, 1'b0} + 6'd2;
  assign wptr      = wptr_q;
  assign addr_byte = mem_q[0];
  assign word      = {mem_q[hi_idx], mem_q[lo_idx]};

endmodule

// File: rtl/spi_scene_loader.sv
// Frames the SPI_Slave byte stream into packets, writes validated payload words into the
// scene-config register file and raises a commit request for Raytracing_Controller.
module spi_scene_loader
  import scene_cfg_pkg::*;
#(
  parameter int MAX_PAYLOAD = 33,
  parameter int TIMEOUT     = 200000
) (
  input  logic          CLK100MHZ,
  input  logic          ck_rst_,
  input  logic          recv_dv,
  input  logic [7:0]    recv_byte,
  output logic          cfg_we,
  output logic [7:0]    cfg_addr,
  output logic [15:0]   cfg_data,
  output logic          commit_req,
  input  logic          commit_ack,
  output logic          pkt_ok,
  output logic          pkt_err,
  output logic [7:0]    err_count,
  output logic          busy,
  output loader_state_t dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshake: recv_dv is a one-cycle strobe qualifying recv_byte, there is no ready/backpressure;
  // cfg_we qualifies cfg_addr/cfg_data for one cycle per word; commit_req is held until commit_ack
  // is sampled high while it is set.

  loader_state_t state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    idx_q, idx_d;
  logic          commit_q, commit_d;
  logic [7:0]    err_q, err_d;
  logic          ok_q, ok_d;
  logic          perr_q, perr_d;

  logic          buf_clr;
  logic          buf_we;
  logic [5:0]    buf_wptr;
  logic [7:0]    buf_addr_byte;
  logic [15:0]   buf_word;
  logic          timed_out;
  logic [3:0]    last_idx;

  spi_payload_buf #(
    .DEPTH(MAX_PAYLOAD)
  ) u_buf (
    .clk      (CLK100MHZ),
    .rst      (ck_rst_),
    .clr      (buf_clr),
    .we       (buf_we),
    .wdata    (recv_byte),
    .word_idx (idx_q),
    .wptr     (buf_wptr),
    .addr_byte(buf_addr_byte),
    .word     (buf_word)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst_) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      len_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      idx_q      <= '0;
      commit_q   <= 1'b0;
      err_q      <= '0;
      ok_q       <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      idx_q      <= idx_d;
      commit_q   <= commit_d;
      err_q      <= err_d;
      ok_q       <= ok_d;
      perr_q     <= perr_d;
    end
  end

  assign last_idx  = 4'(word_count(len_q) - 8'd1);
  assign timed_out = (state_q inside {CMD, LEN, PAYLOAD, CSUM}) && !recv_dv &&
                     (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    len_d      = len_q;
    csum_d     = csum_q;
    idx_d      = idx_q;
    commit_d   = commit_q;
    ok_d       = 1'b0;
    perr_d     = 1'b0;
    buf_clr    = 1'b0;
    buf_we     = 1'b0;

    if (recv_dv || (state_q inside {IDLE, DRAIN})) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (commit_q && commit_ack) begin
      commit_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (recv_dv && (recv_byte == SYNC_BYTE)) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (recv_dv) begin
          if ((recv_byte == CMD_WRITE) || (recv_byte == CMD_COMMIT)) begin
            is_write_d = (recv_byte == CMD_WRITE);
            csum_d     = recv_byte;
            state_d    = LEN;
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      LEN: begin
        if (recv_dv) begin
          len_d  = recv_byte;
          csum_d = csum_q ^ recv_byte;
          if (is_write_q && recv_byte[0] && (recv_byte >= 8'd3) &&
              (recv_byte <= 8'(MAX_PAYLOAD))) begin
            buf_clr = 1'b1;
            state_d = PAYLOAD;
          end else if (!is_write_q && (recv_byte == 8'd0)) begin
            state_d = CSUM;
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (recv_dv) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ recv_byte;
          if ({2'b00, buf_wptr} == (len_q - 8'd1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (recv_dv) begin
          if (recv_byte == csum_q) begin
            ok_d = 1'b1;
            if (is_write_q) begin
              idx_d   = '0;
              state_d = DRAIN;
            end else begin
              commit_d = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        // A byte arriving mid-drain is lost; flag it but finish the writes already validated.
        if (recv_dv) begin
          perr_d = 1'b1;
        end
        if (idx_q == last_idx) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timed_out) begin
      perr_d  = 1'b1;
      state_d = IDLE;
    end

    if (perr_d && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  assign cfg_we     = (state_q == DRAIN);
  assign cfg_addr   = cfg_we ? (buf_addr_byte + {4'b0000, idx_q}) : 8'h00;
  assign cfg_data   = cfg_we ? buf_word : 16'h0000;
  assign commit_req = commit_q;
  assign pkt_ok     = ok_q;
  assign pkt_err    = perr_q;
  assign err_count  = err_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_scene_loader.sv
// Directed bench for spi_scene_loader: expected writes and packet verdicts are queued by the
// stimulus and popped by an independent monitor on the falling edge.
module tb_spi_scene_loader;
  import scene_cfg_pkg::*;

  localparam int TMO = 300;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          recv_dv = 1'b0;
  logic [7:0]    recv_byte = 8'h00;
  logic          commit_ack = 1'b0;
  logic          cfg_we;
  logic [7:0]    cfg_addr;
  logic [15:0]   cfg_data;
  logic          commit_req;
  logic          pkt_ok;
  logic          pkt_err;
  logic [7:0]    err_count;
  logic          busy;
  loader_state_t dbg_state;

  spi_scene_loader #(
    .MAX_PAYLOAD(33),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK100MHZ (clk),
    .ck_rst_   (rst),
    .recv_dv   (recv_dv),
    .recv_byte (recv_byte),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .commit_req(commit_req),
    .commit_ack(commit_ack),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_count (err_count),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  logic [23:0] exp_q[$];
  logic        exp_pkt_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Driver tasks
  task automatic send_seq();
    foreach (tx_q[i]) begin
      repeat (2) @(negedge clk);
      recv_dv   = 1'b1;
      recv_byte = tx_q[i];
      @(negedge clk);
      recv_dv   = 1'b0;
    end
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic exp_ok();
    exp_pkt_q.push_back(1'b1);
  endtask

  task automatic exp_bad();
    exp_pkt_q.push_back(1'b0);
    if (exp_err < 255) exp_err++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (cfg_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cfg_unexpected: got %0h/%0h expected no write", cfg_addr, cfg_data);
      end else begin
        check("cfg_write", {8'h00, cfg_addr, cfg_data}, {8'h00, exp_q.pop_front()});
      end
    end
    if ((pkt_ok === 1'b1) || (pkt_err === 1'b1)) begin
      if (exp_pkt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pkt_unexpected: got ok=%0b err=%0b expected none", pkt_ok, pkt_err);
      end else begin
        check("pkt_verdict", {30'd0, pkt_err, pkt_ok}, exp_pkt_q.pop_front() ? 32'd1 : 32'd2);
      end
    end
  end

  initial begin : main
    logic [7:0]  cs;
    logic [15:0] w;
    int          lows;

    // Reset state
    idle(3);
    check("rst_cfg_we", cfg_we, 0);
    check("rst_commit_req", commit_req, 0);
    check("rst_pkt_ok", pkt_ok, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_busy", busy, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    idle(2);

    // Basic WRITE, two words; checksum 10^05^04^12^34^AB^CD = 51
    exp_write(8'h04, 16'h1234);
    exp_write(8'h05, 16'hABCD);
    exp_ok();
    tx_q = {8'h33, 8'hA5, 8'h10, 8'h05, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h51};
    send_seq();
    check("wr_first_we", cfg_we, 1);
    check("wr_pkt_ok_lat", pkt_ok, 1);
    idle(1);
    check("wr_second_we", cfg_we, 1);
    idle(1);
    check("wr_drain_done", cfg_we, 0);
    check("wr_idle", busy, 0);
    idle(4);

    // Address wrap FF -> 00; checksum E9
    exp_write(8'hFF, 16'h0001);
    exp_write(8'h00, 16'h0002);
    exp_ok();
    tx_q = {8'hA5, 8'h10, 8'h05, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'hE9};
    send_seq();
    idle(6);

    // Bad checksum: no writes
    exp_bad();
    tx_q = {8'hA5, 8'h10, 8'h05, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
    send_seq();
    check("csum_err_count", err_count, 32'(exp_err));
    idle(6);

    // COMMIT held until ack
    exp_ok();
    tx_q = {8'hA5, 8'h20, 8'h00, 8'h20};
    send_seq();
    check("commit_rise", commit_req, 1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (commit_req !== 1'b1) lows++;
    end
    check("commit_hold", lows, 0);
    // WRITE and a second COMMIT while pending
    exp_write(8'h04, 16'h1234);
    exp_write(8'h05, 16'hABCD);
    exp_ok();
    tx_q = {8'hA5, 8'h10, 8'h05, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h51};
    send_seq();
    idle(4);
    exp_ok();
    tx_q = {8'hA5, 8'h20, 8'h00, 8'h20};
    send_seq();
    check("commit_merged", commit_req, 1);
    commit_ack = 1'b1;
    @(negedge clk);
    commit_ack = 1'b0;
    check("commit_fall", commit_req, 0);
    commit_ack = 1'b1;
    idle(2);
    commit_ack = 1'b0;
    check("ack_while_low", commit_req, 0);

    // Timeout mid-packet, then a valid packet (10^03^20^BE^EF = 62)
    exp_bad();
    tx_q = {8'hA5, 8'h10, 8'h03};
    send_seq();
    check("tmo_busy_before", busy, 1);
    idle(TMO + 10);
    check("tmo_idle", busy, 0);
    check("tmo_err_count", err_count, 32'(exp_err));
    exp_write(8'h20, 16'hBEEF);
    exp_ok();
    tx_q = {8'hA5, 8'h10, 8'h03, 8'h20, 8'hBE, 8'hEF, 8'h62};
    send_seq();
    idle(4);

    // Bad LEN / CMD values
    exp_bad();
    tx_q = {8'hA5, 8'h10, 8'hFF};
    send_seq();
    exp_bad();
    tx_q = {8'hA5, 8'h30};
    send_seq();
    exp_bad();
    tx_q = {8'hA5, 8'h10, 8'h04};
    send_seq();
    exp_bad();
    tx_q = {8'hA5, 8'h10, 8'h23};
    send_seq();
    exp_bad();
    tx_q = {8'hA5, 8'h20, 8'h01};
    send_seq();
    idle(2);
    check("len_err_count", err_count, 32'(exp_err));
    check("len_idle", busy, 0);

    // Max-length WRITE (LEN 33, 16 words, wraps from F8), then a byte during drain
    tx_q = {8'hA5, 8'h10, 8'h21, 8'hF8};
    cs = 8'h10 ^ 8'h21 ^ 8'hF8;
    for (int i = 0; i < 16; i++) begin
      w = 16'hA000 + 16'(i) * 16'h0111;
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
      exp_write(8'hF8 + 8'(i), w);
    end
    tx_q.push_back(cs);
    exp_ok();
    exp_bad();
    send_seq();
    recv_dv   = 1'b1;
    recv_byte = 8'hA5;
    @(negedge clk);
    recv_dv   = 1'b0;
    check("drain_continues", cfg_we, 1);
    idle(20);
    check("drain_err_count", err_count, 32'(exp_err));

    // Reset mid-PAYLOAD; trailing bytes are ignored silently afterwards
    tx_q = {8'hA5, 8'h10, 8'h05, 8'h04, 8'h12};
    send_seq();
    check("mid_payload_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    check("rst_payload_busy", busy, 0);
    check("rst_payload_we", cfg_we, 0);
    check("rst_payload_errcnt", err_count, 0);
    tx_q = {8'h34, 8'hAB, 8'hCD, 8'h51};
    send_seq();
    idle(4);

    // Reset mid-DRAIN, with a commit pending
    exp_ok();
    tx_q = {8'hA5, 8'h20, 8'h00, 8'h20};
    send_seq();
    tx_q = {8'hA5, 8'h10, 8'h21, 8'h40};
    cs = 8'h10 ^ 8'h21 ^ 8'h40;
    for (int i = 0; i < 16; i++) begin
      w = 16'h1000 + 16'(i);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    tx_q.push_back(cs);
    exp_ok();
    exp_write(8'h40, 16'h1000);
    exp_write(8'h41, 16'h1001);
    send_seq();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_drain_we", cfg_we, 0);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_commit", commit_req, 0);
    idle(20);

    // err_count saturation
    for (int i = 0; i < 256; i++) begin
      exp_bad();
      tx_q = {8'hA5, 8'h30};
      send_seq();
    end
    idle(3);
    check("err_saturate", err_count, 255);

    idle(5);
    check("cfg_queue_empty", exp_q.size(), 0);
    check("pkt_queue_empty", exp_pkt_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
